multdiv_unit: RTL and testbench

//  Multi-cycle signed multiply/divide responder for the execute stage.
//  X stage issues a 1-cycle MULT or DIV request with operands. Unit computes

---
 rtl/multdiv_unit_if.sv | 30 +++
 rtl/multdiv_unit.sv | 165 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: request/response bundle between the execute stage and
// the multi-cycle multiply/divide unit.
//   operandA/operandB : two's-complement operands, sampled on the start edge
//   ctrl_MULT/ctrl_DIV: 1-cycle start pulses (MULT has priority)
//   result/exception  : registered result and overflow/divide-by-zero flag
//   resultRDY         : 1-cycle pulse, result/exception valid
//   busy              : operation in flight
// master = caller (pipeline), slave = the unit.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             resultRDY;
    logic             busy;

    modport master (
        output operandA, operandB, ctrl_MULT, ctrl_DIV,
        input  result, exception, resultRDY, busy
    );

    modport slave (
        input  operandA, operandB, ctrl_MULT, ctrl_DIV,
        output result, exception, resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes). Every operation takes exactly WIDTH
// iterations after the start edge; results are registered.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : multdiv_unit_if slave (operands, start pulses, result,
//           exception, resultRDY pulse, busy)
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            reset,
    multdiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiplicand during MUL, divisor magnitude during DIV.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Booth register: {hi (WIDTH+1), multiplier (WIDTH), q[-1]}.
    logic [2*WIDTH+1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH+1:0] booth_next;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign bus.result    = result_q;
    assign bus.exception = exc_q;
    assign bus.resultRDY = rdy_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        // One Booth step: add/subtract the multiplicand into the high half,
        // then arithmetic shift right of the whole register.
        hi_sum = prod_q[2*WIDTH+1:WIDTH+1];
        case (prod_q[1:0])
            2'b01:   hi_sum = prod_q[2*WIDTH+1:WIDTH+1] + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   hi_sum = prod_q[2*WIDTH+1:WIDTH+1] - {opnd_q[WIDTH-1], opnd_q};
            default: hi_sum = prod_q[2*WIDTH+1:WIDTH+1];
        endcase
        booth_next = {hi_sum[WIDTH], hi_sum, prod_q[WIDTH:1]};

        // One restoring-division step on unsigned magnitudes.
        r_shift = {rem_q, quo_q[WIDTH-1]};
        diff    = r_shift - {1'b0, opnd_q};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = r_shift[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start pulse in any state (re)starts; an in-flight op is dropped.
        if (bus.ctrl_MULT) begin
            state_d = MUL;
            cnt_d   = '0;
            opnd_d  = bus.operandA;
            prod_d  = {{(WIDTH+1){1'b0}}, bus.operandB, 1'b0};
        end else if (bus.ctrl_DIV) begin
            state_d = DIV;
            cnt_d   = '0;
            opnd_d  = bus.operandB[WIDTH-1] ? -bus.operandB : bus.operandB;
            quo_d   = bus.operandA[WIDTH-1] ? -bus.operandA : bus.operandA;
            rem_d   = '0;
            neg_d   = bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1];
            dz_d    = (bus.operandB == '0);
            ovf_d   = (bus.operandA == MIN_NEG) && (bus.operandB == '1);
        end else begin
            case (state_q)
                MUL: begin
                    prod_d = booth_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        result_d = booth_next[WIDTH:1];
                        // Signed overflow: bits [2W-1:W-1] of the product differ.
                        exc_d    = !((booth_next[2*WIDTH:WIDTH] == '0) ||
                                     (booth_next[2*WIDTH:WIDTH] == '1));
                        rdy_d    = 1'b1;
                    end
                end
                DIV: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        // MIN/-1 has equal signs, so the raw magnitude is MIN already.
                        if (dz_q)
                            result_d = '0;
                        else
                            result_d = neg_q ? -quo_next : quo_next;
                        exc_d = dz_q | ovf_q;
                        rdy_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomized checks of multdiv_unit (WIDTH=32). Inputs are
// driven and outputs sampled on the falling edge.
module tb_multdiv_unit;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    multdiv_unit_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a start pulse for exactly one rising edge; returns at the
    // falling edge right after the start edge.
    task automatic issue(input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b);
        bus.operandA  = a;
        bus.operandB  = b;
        bus.ctrl_MULT = m;
        bus.ctrl_DIV  = d;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    // Waits (bounded) for resultRDY; lat = falling edges after start edge.
    task automatic wait_rdy(output logic [31:0] res, output logic exc,
                            output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        res    = 'x;
        exc    = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.resultRDY === 1'b1) begin
                res = bus.result;
                exc = bus.exception;
                lat = n;
                break;
            end
            @(negedge clock);
        end
    endtask

    function automatic void ref_op(input bit is_mul, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({bus.busy, bus.resultRDY, bus.exception} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.busy, bus.resultRDY, bus.exception});
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 32'd0) $display("FAIL reset_result got %h want 00000000", bus.result);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mult_basic();
        logic [31:0] r;
        logic        e;
        int          lat, bn, extra;
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        wait_rdy(r, e, lat, bn);
        total_cnt++;
        if (r !== 32'hFFFF_FFD6) $display("FAIL mul_7x-6 result got %h want ffffffd6", r);
        else pass_cnt++;
        total_cnt++;
        if (e !== 1'b0) $display("FAIL mul_7x-6 exc got %b want 0", e);
        else pass_cnt++;
        total_cnt++;
        if (lat != 33) $display("FAIL mul_latency got %0d want 33", lat);
        else pass_cnt++;
        total_cnt++;
        if (bn != 32) $display("FAIL mul_busy_cycles got %0d want 32", bn);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL busy_at_ready got %b want 0", bus.busy);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.resultRDY === 1'b1) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL rdy_single_pulse got %0d extra want 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 32'hFFFF_FFD6) $display("FAIL result_hold got %h want ffffffd6", bus.result);
        else pass_cnt++;
    endtask

    task automatic test_mult_overflow();
        logic [31:0] a_t[4] = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t[4] = '{32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] r_t[4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        logic        e_t[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] r;
        logic        e;
        int          lat, bn;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, a_t[i], b_t[i]);
            wait_rdy(r, e, lat, bn);
            total_cnt++;
            if (r !== r_t[i] || e !== e_t[i]) $display("FAIL mul_vec%0d got %h/%b want %h/%b", i, r, e, r_t[i], e_t[i]);
            else pass_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic test_div();
        logic [31:0] a_t[5] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] b_t[5] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] r_t[5] = '{32'hFFFF_FFFD, 32'd0, 32'h8000_0000, 32'd14, 32'd14};
        logic        e_t[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] r;
        logic        e;
        int          lat, bn;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1'b1, a_t[i], b_t[i]);
            wait_rdy(r, e, lat, bn);
            total_cnt++;
            if (r !== r_t[i] || e !== e_t[i] || lat != 33) $display("FAIL div_vec%0d got %h/%b lat %0d want %h/%b lat 33", i, r, e, lat, r_t[i], e_t[i]);
            else pass_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic test_restart();
        logic [31:0] r;
        logic        e;
        int          lat, bn, early, extra;
        early = 0;
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            if (bus.resultRDY === 1'b1) early++;
            @(negedge clock);
        end
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        wait_rdy(r, e, lat, bn);
        total_cnt++;
        if (early != 0) $display("FAIL restart_aborted_rdy got %0d want 0", early);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'd12 || e !== 1'b0 || lat != 33) $display("FAIL restart_mul got %h/%b lat %0d want 0000000c/0 lat 33", r, e, lat);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.resultRDY === 1'b1) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL restart_extra_rdy got %0d want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic        e;
        int          lat, bn, rdy_n;
        issue(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (19) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.exception !== 1'b0) $display("FAIL midreset_state got busy %b res %h exc %b want 0/00000000/0", bus.busy, bus.result, bus.exception);
        else pass_cnt++;
        rdy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resultRDY === 1'b1) rdy_n++;
            @(negedge clock);
        end
        total_cnt++;
        if (rdy_n != 0) $display("FAIL midreset_rdy got %0d want 0", rdy_n);
        else pass_cnt++;
        issue(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy(r, e, lat, bn);
        total_cnt++;
        if (r !== 32'd3 || e !== 1'b0) $display("FAIL midreset_div got %h/%b want 00000003/0", r, e);
        else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_both_ctrl();
        logic [31:0] r;
        logic        e;
        int          lat, bn;
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        bus.operandA = 32'hDEAD_BEEF;
        bus.operandB = 32'h1234_5678;
        wait_rdy(r, e, lat, bn);
        total_cnt++;
        if (r !== 32'd18 || e !== 1'b0) $display("FAIL both_ctrl got %h/%b want 00000012/0", r, e);
        else pass_cnt++;
        issue(1'b0, 1'b1, 32'd50, 32'hFFFF_FFFB);
        repeat (5) @(negedge clock);
        bus.operandA = 32'd1;
        bus.operandB = 32'd0;
        wait_rdy(r, e, lat, bn);
        total_cnt++;
        if (r !== 32'hFFFF_FFF6 || e !== 1'b0) $display("FAIL operand_change got %h/%b want fffffff6/0", r, e);
        else pass_cnt++;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic        e, ee;
        bit          is_mul;
        int          lat, bn;
        for (int i = 0; i < 300; i++) begin
            is_mul = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 40) - 20;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = $urandom_range(0, 6) - 3;
                1:       b = $urandom & 32'h0000_FFFF;
                default: b = $urandom;
            endcase
            ref_op(is_mul, a, b, er, ee);
            issue(is_mul, !is_mul, a, b);
            wait_rdy(r, e, lat, bn);
            total_cnt++;
            if (r !== er || e !== ee || lat != 33) $display("FAIL rand%0d %s a=%h b=%h got %h/%b lat %0d want %h/%b", i, is_mul ? "mul" : "div", a, b, r, e, lat, er, ee);
            else pass_cnt++;
            @(negedge clock);
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b0;
        bus.operandA  = '0;
        bus.operandB  = '0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        @(negedge clock);
        test_reset();
        test_mult_basic();
        test_mult_overflow();
        test_div();
        test_restart();
        test_reset_mid_op();
        test_both_ctrl();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
